// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: control sequencer for the FP16 MAC (clear, issue pops, drain pipeline, push result); job of N pairs takes N+4+MAC_LATENCY cycles.
// Backpressure: issue stalls while either operand FIFO is empty; result push holds on res_full. Optional stall counter under MAC_SEQ_PERF_EN.
module mac_seq_ctrl #(
  parameter int LEN_WIDTH   = 10,
  parameter int MAC_LATENCY = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] vec_len,
  output logic                 busy,
  output logic                 done,
  output logic                 len_err,
  input  logic                 a_empty,
  input  logic                 b_empty,
  output logic                 a_r_en,
  output logic                 b_r_en,
  input  logic                 res_full,
  output logic                 res_w_en,
  output logic                 mac_clr,
  output logic                 mac_valid,
  output logic [31:0]          stall_cnt
);

  localparam logic [LEN_WIDTH-1:0] ONE = LEN_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0] LAT = LEN_WIDTH'(MAC_LATENCY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ISSUE,
    S_DRAIN,
    S_WRITE
  } state_t;

  state_t               state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] issued_q, issued_d;
  logic [LEN_WIDTH-1:0] drain_cnt_q, drain_cnt_d;
  logic                 mac_valid_q, mac_valid_d;
  logic                 len_err_q, len_err_d;
  logic                 pop;

  // Both FIFOs pop together or not at all, so operand pairs never skew.
  assign pop = (state_q == S_ISSUE) && !a_empty && !b_empty;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    issued_d    = issued_q;
    drain_cnt_d = drain_cnt_q;
    mac_valid_d = pop;
    len_err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (vec_len != '0) begin
            len_d    = vec_len;
            issued_d = '0;
            state_d  = S_CLEAR;
          end else begin
            len_err_d = 1'b1;
          end
        end
      end
      S_CLEAR: state_d = S_ISSUE;
      S_ISSUE: begin
        if (pop) begin
          issued_d = issued_q + ONE;
          if (issued_q == len_q - ONE) begin
            drain_cnt_d = LAT;
            state_d     = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == '0) begin
          state_d = S_WRITE;
        end else begin
          drain_cnt_d = drain_cnt_q - ONE;
        end
      end
      S_WRITE: begin
        if (!res_full) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      issued_q    <= '0;
      drain_cnt_q <= '0;
      mac_valid_q <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      drain_cnt_q <= drain_cnt_d;
      mac_valid_q <= mac_valid_d;
      len_err_q   <= len_err_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign mac_clr   = (state_q == S_CLEAR);
  assign res_w_en  = (state_q == S_WRITE) && !res_full;
  assign done      = res_w_en;
  assign a_r_en    = pop;
  assign b_r_en    = pop;
  assign mac_valid = mac_valid_q;
  assign len_err   = len_err_q;

`ifdef MAC_SEQ_PERF_EN
  logic [31:0] stall_q, stall_d;
  logic        stall_ev;

  // Counts issue cycles lacking an operand pair and write cycles blocked by a full result FIFO.
  always_comb begin
    stall_ev = ((state_q == S_ISSUE) && !pop) || ((state_q == S_WRITE) && res_full);
    stall_d  = stall_q;
    if (stall_ev && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: whole-run stimulus tables (directed prefix + random tail) and a job-level schedule model.
module tb_mac_seq_ctrl;

  localparam int LW = 10;
  localparam int ML = 3;
  localparam int NC = 6000;
  localparam int R0 = 1200;
`ifdef MAC_SEQ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, start, a_empty, b_empty, res_full;
  logic [LW-1:0] vec_len;
  logic          busy, done, len_err, a_r_en, b_r_en, res_w_en, mac_clr, mac_valid;
  logic [31:0]   stall_cnt;

  mac_seq_ctrl #(.LEN_WIDTH(LW), .MAC_LATENCY(ML)) dut (
    .clk(clk), .rst(rst), .start(start), .vec_len(vec_len),
    .busy(busy), .done(done), .len_err(len_err),
    .a_empty(a_empty), .b_empty(b_empty), .a_r_en(a_r_en), .b_r_en(b_r_en),
    .res_full(res_full), .res_w_en(res_w_en), .mac_clr(mac_clr),
    .mac_valid(mac_valid), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  bit          st_rst[NC], st_start[NC], st_ae[NC], st_be[NC], st_rf[NC];
  logic [LW-1:0] st_len[NC];
  bit          e_busy[NC], e_clr[NC], e_pop[NC], e_mv[NC], e_wen[NC], e_lerr[NC];
  logic [31:0] e_stall[NC];
  bit          o_busy[NC], o_clr[NC], o_pop[NC], o_mv[NC], o_done[NC], o_lerr[NC];
  logic [31:0] o_stall[NC];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", nm, c, act, exp);
    end
  endtask

  function automatic logic [31:0] sat_inc(input logic [31:0] s);
    return (s == 32'hFFFF_FFFF) ? s : s + 32'd1;
  endfunction

  function automatic int pops_in(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) n += int'(o_pop[i]);
    return n;
  endfunction

  task automatic job(input int c, input int n);
    st_start[c] = 1'b1;
    st_len[c]   = LW'(n);
  endtask

  // Stimulus: cycles 0-1 reset, directed scenarios up to R0, random traffic after.
  task automatic build_stim();
    for (int c = 0; c < NC; c++) begin
      st_rst[c] = (c < 2); st_start[c] = 0; st_len[c] = '0;
      st_ae[c] = 0; st_be[c] = 0; st_rf[c] = 0;
    end
    job(5, 4);
    job(20, 3);
    for (int c = 23; c <= 25; c++) st_be[c] = 1'b1;
    job(40, 2);
    for (int c = 48; c <= 52; c++) st_rf[c] = 1'b1;
    job(60, 0);
    job(63, 5);
    job(66, 7);
    job(80, 6);
    st_rst[89] = 1'b1;
    job(92, 2);
    job(110, 1023);
    for (int c = R0; c < NC; c++) begin
      st_rst[c]   = ($urandom_range(0, 499) == 0);
      st_start[c] = ($urandom_range(0, 4) == 0);
      st_len[c]   = ($urandom_range(0, 7) == 0) ? '0 : LW'($urandom_range(1, 12));
      st_ae[c]    = ($urandom_range(0, 3) == 0);
      st_be[c]    = ($urandom_range(0, 3) == 0);
      st_rf[c]    = ($urandom_range(0, 4) == 0);
    end
  endtask

  // Job-level model: accept -> one clear cycle -> N paired pops (stalling on
  // empties) -> MAC_LATENCY+1 drain cycles -> write once not full. rst aborts.
  task automatic build_model();
    int c, n, pops;
    bit ab, mv, lerr, fin;
    logic [31:0] stall;
    for (int i = 0; i < NC; i++) begin
      e_busy[i] = 0; e_clr[i] = 0; e_pop[i] = 0; e_mv[i] = 0;
      e_wen[i] = 0; e_lerr[i] = 0; e_stall[i] = '0;
    end
    c = 1; mv = 0; lerr = 0; stall = '0;
    while (c < NC) begin
      e_lerr[c] = lerr; e_mv[c] = mv; e_stall[c] = stall;
      lerr = 0; mv = 0;
      if (st_rst[c]) begin stall = '0; c++; continue; end
      if (!st_start[c]) begin c++; continue; end
      if (st_len[c] == '0) begin lerr = 1; c++; continue; end
      n = int'(st_len[c]); c++; ab = 0;
      if (c < NC) begin
        e_busy[c] = 1; e_clr[c] = 1; e_stall[c] = stall;
        ab = st_rst[c]; c++;
      end
      pops = 0;
      while (!ab && pops < n && c < NC) begin
        e_busy[c] = 1; e_mv[c] = mv; e_stall[c] = stall;
        e_pop[c] = !st_ae[c] && !st_be[c];
        mv = e_pop[c];
        if (st_rst[c]) ab = 1;
        else if (e_pop[c]) pops++;
        else stall = sat_inc(stall);
        c++;
      end
      for (int d = 0; d <= ML && !ab && c < NC; d++) begin
        e_busy[c] = 1; e_mv[c] = mv; e_stall[c] = stall;
        mv = 0; ab = st_rst[c]; c++;
      end
      while (!ab && c < NC) begin
        e_busy[c] = 1; e_mv[c] = mv; e_stall[c] = stall;
        mv = 0;
        e_wen[c] = !st_rf[c];
        fin = e_wen[c];
        if (st_rst[c]) ab = 1;
        else if (st_rf[c]) stall = sat_inc(stall);
        c++;
        if (fin || ab) break;
      end
      if (ab) begin stall = '0; mv = 0; end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; vec_len = '0;
    a_empty = 1'b0; b_empty = 1'b0; res_full = 1'b0;
    build_stim();
    build_model();
    for (int c = 0; c < NC; c++) begin
      @(negedge clk);
      rst = st_rst[c]; start = st_start[c]; vec_len = st_len[c];
      a_empty = st_ae[c]; b_empty = st_be[c]; res_full = st_rf[c];
      #2;
      o_busy[c] = busy; o_clr[c] = mac_clr; o_pop[c] = a_r_en; o_mv[c] = mac_valid;
      o_done[c] = done; o_lerr[c] = len_err; o_stall[c] = stall_cnt;
      if (c >= 1) begin
        chk("busy",      c, 32'(busy),      32'(e_busy[c]));
        chk("mac_clr",   c, 32'(mac_clr),   32'(e_clr[c]));
        chk("a_r_en",    c, 32'(a_r_en),    32'(e_pop[c]));
        chk("b_r_en",    c, 32'(b_r_en),    32'(e_pop[c]));
        chk("mac_valid", c, 32'(mac_valid), 32'(e_mv[c]));
        chk("res_w_en",  c, 32'(res_w_en),  32'(e_wen[c]));
        chk("done",      c, 32'(done),      32'(e_wen[c]));
        chk("len_err",   c, 32'(len_err),   32'(e_lerr[c]));
        chk("stall_cnt", c, stall_cnt,      PERF ? e_stall[c] : 32'd0);
      end
    end

    // Hand-derived timing anchors for the directed prefix.
    chk("t1_clr",      6,  32'(o_clr[6]), 32'd1);
    chk("t1_no_early", 6,  32'(o_pop[6]), 32'd0);
    chk("t1_pops",     7,  32'(pops_in(7, 10)), 32'd4);
    chk("t1_no_extra", 11, 32'(o_pop[11]), 32'd0);
    chk("t1_mv_first", 8,  32'(o_mv[8]), 32'd1);
    chk("t1_mv_last",  11, 32'(o_mv[11]), 32'd1);
    chk("t1_mv_end",   12, 32'(o_mv[12]), 32'd0);
    chk("t1_done",     15, 32'(o_done[15]), 32'd1);
    chk("t1_busy_hi",  15, 32'(o_busy[15]), 32'd1);
    chk("t1_busy_lo",  16, 32'(o_busy[16]), 32'd0);
    chk("t2_gap",      23, 32'(pops_in(23, 25)), 32'd0);
    chk("t2_pops",     20, 32'(pops_in(20, 35)), 32'd3);
    chk("t2_done",     32, 32'(o_done[32]), 32'd1);
    chk("t2_stall",    40, o_stall[40], PERF ? 32'd3 : 32'd0);
    chk("t3_held",     48, 32'(o_done[48]), 32'd0);
    chk("t3_done",     53, 32'(o_done[53]), 32'd1);
    chk("t3_stall",    60, o_stall[60], PERF ? 32'd8 : 32'd0);
    chk("t4_len_err",  61, 32'(o_lerr[61]), 32'd1);
    chk("t4_idle",     61, 32'(o_busy[61]), 32'd0);
    chk("t4_pops",     63, 32'(pops_in(60, 79)), 32'd5);
    chk("t4_done",     74, 32'(o_done[74]), 32'd1);
    chk("t5_rst_busy", 90, 32'(o_busy[90]), 32'd0);
    chk("t5_rst_mv",   90, 32'(o_mv[90]), 32'd0);
    chk("t5_rst_stall",90, o_stall[90], 32'd0);
    chk("t5_done",     100, 32'(o_done[100]), 32'd1);
    chk("t6_pops",     110, 32'(pops_in(110, 1199)), 32'd1023);
    chk("t6_last_mv",  1135, 32'(o_mv[1135]), 32'd1);
    chk("t6_mv_end",   1136, 32'(o_mv[1136]), 32'd0);
    chk("t6_done",     1139, 32'(o_done[1139]), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
